ro_freq_counter: RTL and testbench

Measurement-side companion to the configurable ring oscillator. On request it applies a 6-bit challenge to the oscillator's SEL/BX configuration inputs, enables the oscillator for a fixed window of system clocks, and counts rising edges of the oscillator output. It then presents the count with a valid/ack handshake to the response logic, which compares oscillators for PUF bit generation. The input must be divided or slow enough that its frequency is below CLK/4.

---
 rtl/ro_freq_counter.sv | 182 ++++++++++++++++++
 tb/tb_ro_freq_counter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
//==============================================================================
// Module      : ro_freq_counter
// Description : Applies a challenge to a ring oscillator, enables it for a fixed
//               window and counts its synchronized rising edges (valid/ack out).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ro_freq_counter #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [5:0]       CHALLENGE,
    input  logic             ACK,
    output logic [2:0]       SEL,
    output logic [2:0]       BX,
    output logic             RO_EN,
    input  logic             RO_IN,
    output logic             BUSY,
    output logic [CNT_W-1:0] COUNT,
    output logic             VALID,
    output logic             OVF
);

    localparam int c_drain_cycles = SYNC_STAGES + 1;
    localparam int c_tmr_max_a    = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int c_tmr_max      = (c_tmr_max_a > c_drain_cycles) ? c_tmr_max_a : c_drain_cycles;
    localparam int c_tmr_w        = $clog2(c_tmr_max + 1);

    localparam logic [c_tmr_w-1:0] c_settle_last = c_tmr_w'(SETTLE_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_window_last = c_tmr_w'(WINDOW_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_drain_last  = c_tmr_w'(c_drain_cycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [c_tmr_w-1:0]     timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic [2:0]             sel_q, sel_d;
    logic [2:0]             bx_q, bx_d;

    logic                   w_rise;
    logic                   w_cnt_en;
    logic [CNT_W-1:0]       w_cnt_upd;
    logic                   w_ovf_upd;

    // RO_IN is asynchronous; only the last synchronizer stage is trusted.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], RO_IN};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign w_rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign w_cnt_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Saturating edge counter: an edge arriving at full scale sets OVF instead of wrapping.
    always_comb begin
        w_cnt_upd = cnt_q;
        w_ovf_upd = ovf_q;
        if (w_cnt_en && w_rise) begin
            if (cnt_q == {CNT_W{1'b1}}) begin
                w_ovf_upd = 1'b1;
            end else begin
                w_cnt_upd = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = w_cnt_upd;
        ovf_d   = w_ovf_upd;
        count_d = count_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        bx_d    = bx_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sel_d   = CHALLENGE[2:0];
                    bx_d    = CHALLENGE[5:3];
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == c_settle_last) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            ST_RUN: begin
                if (timer_q == c_window_last) begin
                    timer_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            ST_DRAIN: begin
                // Capture includes an edge landing in the final drain cycle.
                if (timer_q == c_drain_last) begin
                    timer_d = '0;
                    count_d = w_cnt_upd;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + c_tmr_w'(1);
                end
            end
            ST_DONE: begin
                if (ACK) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            sel_q   <= 3'd0;
            bx_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            bx_q    <= bx_d;
        end
    end

    assign SEL   = sel_q;
    assign BX    = bx_q;
    assign RO_EN = (state_q == ST_RUN);
    assign BUSY  = (state_q != ST_IDLE);
    assign COUNT = count_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
//==============================================================================
// Module      : tb_ro_freq_counter
// Description : Self-checking bench for ro_freq_counter (vector table + scoreboard).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ro_freq_counter;

    localparam int W  = 100;
    localparam int S  = 4;
    localparam int SY = 2;
    localparam int CW = 4;
    localparam int LATENCY = 1 + S + W + SY + 1;

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic [5:0]    CHALLENGE;
    logic          ACK;
    logic [2:0]    SEL;
    logic [2:0]    BX;
    logic          RO_EN;
    logic          RO_IN;
    logic          BUSY;
    logic [CW-1:0] COUNT;
    logic          VALID;
    logic          OVF;

    ro_freq_counter #(
        .WINDOW_CYCLES (W),
        .SETTLE_CYCLES (S),
        .SYNC_STAGES   (SY),
        .CNT_W         (CW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .CHALLENGE (CHALLENGE),
        .ACK       (ACK),
        .SEL       (SEL),
        .BX        (BX),
        .RO_EN     (RO_EN),
        .RO_IN     (RO_IN),
        .BUSY      (BUSY),
        .COUNT     (COUNT),
        .VALID     (VALID),
        .OVF       (OVF)
    );

    typedef struct {
        logic [CW-1:0] count;
        logic          ovf;
        logic [2:0]    sel;
        logic [2:0]    bx;
    } exp_t;

    typedef struct {
        logic [5:0]    chal;
        int            period;
        logic [CW-1:0] count;
        logic          ovf;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int en_cnt   = 0;
    int ro_period = 0;
    int ph       = 0;
    bit gen_on   = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Square-wave oscillator model: starts low at RUN entry, forced low otherwise.
    initial begin
        RO_IN = 1'b0;
        forever begin
            @(negedge CLK);
            if (gen_on) begin
                if (RO_EN && ro_period != 0) begin
                    RO_IN = (ph >= ro_period / 2);
                    ph    = (ph + 1) % ro_period;
                end else begin
                    RO_IN = 1'b0;
                    ph    = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        lat++;
        if (RO_EN) en_cnt++;
    endtask

    task automatic start_meas(input logic [5:0] chal, input logic [CW-1:0] cnt, input logic ovf);
        exp_t e;
        @(negedge CLK);
        START     = 1'b1;
        CHALLENGE = chal;
        e.count = cnt;
        e.ovf   = ovf;
        e.sel   = chal[2:0];
        e.bx    = chal[5:3];
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        START     = 1'b0;
        CHALLENGE = ~chal;
        lat       = 1;
        en_cnt    = 0;
        chk("sel_capture", 32'(SEL), 32'(chal[2:0]));
        chk("bx_capture", 32'(BX), 32'(chal[5:3]));
        chk("busy_after_start", 32'(BUSY), 32'd1);
    endtask

    task automatic wait_valid();
        exp_t e;
        while (VALID !== 1'b1 && lat < 300) step();
        if (VALID !== 1'b1) begin
            chk("valid_timeout", 32'(VALID), 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(LATENCY));
            chk("ro_en_cycles", 32'(en_cnt), 32'(W));
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("count", 32'(COUNT), 32'(e.count));
                chk("ovf", 32'(OVF), 32'(e.ovf));
                chk("sel_held", 32'(SEL), 32'(e.sel));
                chk("bx_held", 32'(BX), 32'(e.bx));
            end
        end
    endtask

    task automatic ack_done();
        @(negedge CLK);
        ACK = 1'b1;
        @(posedge CLK);
        #1;
        ACK = 1'b0;
        chk("valid_clear", 32'(VALID), 32'd0);
        chk("busy_idle", 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic [CW-1:0] held;
        bit            stable;
        bit            seen_valid;

        vecs[0] = '{chal: 6'b101_011, period: 10, count: 4'd10, ovf: 1'b0};
        vecs[1] = '{chal: 6'b000_111, period: 4,  count: 4'd15, ovf: 1'b1};
        vecs[2] = '{chal: 6'b110_000, period: 0,  count: 4'd0,  ovf: 1'b0};
        vecs[3] = '{chal: 6'b010_101, period: 20, count: 4'd5,  ovf: 1'b0};
        vecs[4] = '{chal: 6'b111_111, period: 8,  count: 4'd12, ovf: 1'b0};
        vecs[5] = '{chal: 6'b001_100, period: 12, count: 4'd8,  ovf: 1'b0};

        RST_N     = 1'b0;
        START     = 1'b0;
        ACK       = 1'b0;
        CHALLENGE = 6'h2A;

        // Reset held while inputs wiggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            START = ~START;
            RO_IN = ~RO_IN;
        end
        #1;
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_bx", 32'(BX), 32'd0);
        chk("rst_ro_en", 32'(RO_EN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        RO_IN = 1'b0;
        RST_N = 1'b1;
        repeat (3) step();
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_valid", 32'(VALID), 32'd0);

        // Vector table: challenge, oscillator period, expected result.
        gen_on = 1'b1;
        for (int v = 0; v < 6; v++) begin
            ro_period = vecs[v].period;
            start_meas(vecs[v].chal, vecs[v].count, vecs[v].ovf);
            wait_valid();
            ack_done();
        end

        // Handshake: START ignored in RUN, VALID held without ACK, START+ACK in DONE.
        ro_period = 20;
        start_meas(6'b011_110, 4'd5, 1'b0);
        while (lat < 30) step();
        START     = 1'b1;
        CHALLENGE = 6'b111_000;
        step();
        START     = 1'b0;
        wait_valid();
        held   = COUNT;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (VALID !== 1'b1 || COUNT !== held || BUSY !== 1'b1) stable = 1'b0;
        end
        chk("done_hold_stable", 32'(stable), 32'd1);
        @(negedge CLK);
        START     = 1'b1;
        ACK       = 1'b1;
        CHALLENGE = 6'b111_111;
        @(posedge CLK);
        #1;
        START = 1'b0;
        ACK   = 1'b0;
        chk("start_ack_valid", 32'(VALID), 32'd0);
        chk("start_ack_idle", 32'(BUSY), 32'd0);
        repeat (3) step();
        chk("start_ack_ignored_busy", 32'(BUSY), 32'd0);
        chk("start_ack_ignored_sel", 32'(SEL), 32'(3'b110));

        // Edge gating: a pulse during SETTLE only is not counted.
        gen_on = 1'b0;
        RO_IN  = 1'b0;
        start_meas(6'b011_010, 4'd0, 1'b0);
        RO_IN = 1'b1;
        step();
        RO_IN = 1'b0;
        wait_valid();
        ack_done();

        // A rise one cycle before RUN ends lands in DRAIN and is counted.
        start_meas(6'b100_001, 4'd1, 1'b0);
        while (lat < W + S - 1) step();
        RO_IN = 1'b1;
        step();
        step();
        RO_IN = 1'b0;
        wait_valid();
        ack_done();

        // Reset abort at RUN cycle 50, then a clean run.
        gen_on    = 1'b1;
        ro_period = 10;
        start_meas(6'b110_101, 4'd10, 1'b0);
        while (lat < S + 1 + 50) step();
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_ro_en", 32'(RO_EN), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_sel", 32'(SEL), 32'd0);
        chk("abort_bx", 32'(BX), 32'd0);
        sb_q.delete(0);
        @(negedge CLK);
        RST_N = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < LATENCY + 10; i++) begin
            step();
            if (VALID !== 1'b0) seen_valid = 1'b1;
        end
        chk("abort_no_valid", 32'(seen_valid), 32'd0);
        start_meas(6'b101_011, 4'd10, 1'b0);
        wait_valid();
        ack_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
